// File: rtl/bus_arbiter_ns.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_ns
// Purpose  : Two-master shared-bus interconnect. A registered GNT0/GNT1 grant
//            FSM with optional hold-timeout preemption selects the owner. The
//            owner's address is region-decoded to a one-hot slave select.
//            Read data comes back through a registered slave-select mux, so
//            reads have one-cycle latency. Unmapped accesses pulse dec_err.
// Ports    : clk, reset_n        clock / async active-low reset
//            m0_* / m1_*         master request, write, address, write data
//            m0_grant, m1_grant  decoded grant state
//            m_din               shared read data (0 when no read returns)
//            s_sel, s_wr, s_addr, s_din  slave-side bus from the owner
//            s_dout              flattened slave read data, slave i at i*DATA_W
//            dec_err             pulse after an access to an unmapped region
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_ns #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 16,
    parameter int NUM_SLAVES = 4,
    parameter int REGION_AW  = 8,
    parameter int MAX_HOLD   = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         m0_req,
    input  logic                         m0_wr,
    input  logic [ADDR_W-1:0]            m0_addr,
    input  logic [DATA_W-1:0]            m0_dout,
    input  logic                         m1_req,
    input  logic                         m1_wr,
    input  logic [ADDR_W-1:0]            m1_addr,
    input  logic [DATA_W-1:0]            m1_dout,
    output logic                         m0_grant,
    output logic                         m1_grant,
    output logic [DATA_W-1:0]            m_din,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic                         s_wr,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_din,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_dout,
    output logic                         dec_err
);

    localparam int IDX_W  = ADDR_W - REGION_AW;
    localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

    typedef enum logic [0:0] {
        GNT0 = 1'b0,
        GNT1 = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic                r_rd_vld;
    logic [SEL_W-1:0]    r_rd_idx;
    logic                r_dec_err;

    logic                w_own1;
    logic                w_req;
    logic                w_wr;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_dout;
    logic [IDX_W-1:0]    w_idx;
    logic                w_mapped;
    logic                w_hold_hit;
    logic [DATA_W-1:0]   w_slv [NUM_SLAVES];

    // ------------------------------------------------------------------
    // Owner mux: only the current owner's access reaches the slave side.
    // ------------------------------------------------------------------
    assign w_own1   = (r_state == GNT1);
    assign w_req    = w_own1 ? m1_req  : m0_req;
    assign w_wr     = w_own1 ? m1_wr   : m0_wr;
    assign w_addr   = w_own1 ? m1_addr : m0_addr;
    assign w_dout   = w_own1 ? m1_dout : m0_dout;
    assign w_idx    = w_addr[ADDR_W-1:REGION_AW];
    assign w_mapped = (32'(w_idx) < 32'(NUM_SLAVES));

    // The owner has used up its hold allowance; only meaningful when
    // preemption is enabled.
    assign w_hold_hit = (MAX_HOLD > 0) && (r_hold_cnt == C_HOLD_LAST);

    // ------------------------------------------------------------------
    // Grant FSM. GNT0 is the park state: GNT1 falls back to it whenever
    // master 1 stops requesting, regardless of master 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            GNT0: begin
                if ((!m0_req && m1_req) || (m0_req && m1_req && w_hold_hit))
                    w_state_nxt = GNT1;
            end
            GNT1: begin
                if (!m1_req || (m0_req && w_hold_hit))
                    w_state_nxt = GNT0;
            end
            default: w_state_nxt = GNT0;
        endcase
    end

    // Hold counter: restarts on a grant change or an idle owner, otherwise
    // counts owner-request cycles and saturates at MAX_HOLD-1.
    always_comb begin
        w_hold_nxt = '0;
        if ((w_state_nxt == r_state) && w_req && (MAX_HOLD > 0)) begin
            if (w_hold_hit)
                w_hold_nxt = r_hold_cnt;
            else
                w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= GNT0;
            r_hold_cnt <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_idx   <= '0;
            r_dec_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            // Remember which slave answers the read issued this cycle; the
            // owner may change at this edge without disturbing the return.
            r_rd_vld   <= w_req && !w_wr && w_mapped;
            r_rd_idx   <= w_idx[SEL_W-1:0];
            r_dec_err  <= w_req && !w_mapped;
        end
    end

    // ------------------------------------------------------------------
    // Slave-side outputs
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sel
            assign s_sel[i] = w_req && w_mapped && (w_idx == IDX_W'(i));
            assign w_slv[i] = s_dout[i*DATA_W +: DATA_W];
        end
    endgenerate

    assign s_wr   = w_wr && (|s_sel);
    assign s_addr = w_addr;
    assign s_din  = w_dout;

    assign m_din    = r_rd_vld ? w_slv[r_rd_idx] : '0;
    assign m0_grant = (r_state == GNT0);
    assign m1_grant = (r_state == GNT1);
    assign dec_err  = r_dec_err;

endmodule
`default_nettype wire

// File: doc/bus_arbiter_ns.md
Name: bus_arbiter_ns

Overview:
Shared-bus interconnect for the system: two masters arbitrate for one slave-side bus that fans out to NUM_SLAVES memory-mapped slaves (RAM, accelerator cores, ...).
- Arbitration is a registered grant FSM with an optional hold-timeout preemption.
- Address decode is region-based.
- Read data returns through a registered slave-select mux, giving one-cycle read latency.
- Unmapped accesses raise a decode-error pulse.

Parameters:
- DATA_W, 64, data width of all master/slave data buses
- ADDR_W, 16, address width
- NUM_SLAVES, 4, number of slaves (1..2^(ADDR_W-REGION_AW))
- REGION_AW, 8, low address bits per slave region; slave i owns addr[ADDR_W-1:REGION_AW]==i
- MAX_HOLD, 0, max consecutive granted cycles before preemption when the other master requests; 0 disables preemption

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- m0_req  input  1  master 0 bus request / access valid
- m0_wr  input  1  master 0 write (1) / read (0)
- m0_addr  input  ADDR_W  master 0 address
- m0_dout  input  DATA_W  master 0 write data
- m1_req  input  1  master 1 bus request / access valid
- m1_wr  input  1  master 1 write / read
- m1_addr  input  ADDR_W  master 1 address
- m1_dout  input  DATA_W  master 1 write data
- m0_grant  output  1  master 0 owns the bus
- m1_grant  output  1  master 1 owns the bus
- m_din  output  DATA_W  read data to masters (shared)
- s_sel  output  NUM_SLAVES  one-hot slave select
- s_wr  output  1  write strobe to slaves
- s_addr  output  ADDR_W  full address to slaves
- s_din  output  DATA_W  write data to slaves
- s_dout  input  NUM_SLAVES*DATA_W  flattened slave read data; slave i at bits [i*DATA_W +: DATA_W]
- dec_err  output  1  one-cycle pulse: previous granted access hit an unmapped region

Behaviour:
Reset (asynchronous, reset_n=0), all registered values:
- state=GNT0, so m0_grant=1 and m1_grant=0
- hold_cnt=0
- rd_sel_q=NONE, so m_din=0
- dec_err=0

Arbiter FSM, states GNT0/GNT1, registered; grant outputs decode the state.
- GNT0: if m0_req=0 and m1_req=1, go to GNT1. If m0_req=1 and m1_req=1 and MAX_HOLD>0 and hold_cnt==MAX_HOLD-1, go to GNT1 (preempt). Otherwise stay.
- GNT1: if m1_req=0, go to GNT0. If m1_req=1 and m0_req=1 and MAX_HOLD>0 and hold_cnt==MAX_HOLD-1, go to GNT0. Otherwise stay.
- Idle bus (no requests) parks at, and returns to, GNT0.
- Grant changes take effect one cycle after the qualifying condition.
- hold_cnt: cleared on any state change. Otherwise increments while the owner's req=1, saturating at MAX_HOLD-1. Cleared when the owner's req=0.
- MAX_HOLD=1 with both masters requesting: grant alternates every cycle.

Slave-side mux (combinational from the current owner):
- s_addr, s_wr, s_din copy the owner's addr/wr/dout.
- idx = owner_addr[ADDR_W-1:REGION_AW].
- s_sel[idx]=1 only if owner_req=1 and idx<NUM_SLAVES; otherwise s_sel=0.
- s_wr is forced to 0 whenever s_sel=0.
- The non-owner's request is never forwarded.

Writes:
- Performed by the selected slave at the clock edge of the same cycle.
- A write to an unmapped region is dropped.

Reads:
- On each edge, rd_sel_q<=idx if owner_req=1, wr=0 and the address is mapped; otherwise rd_sel_q<=NONE.
- m_din = s_dout slice[rd_sel_q], or 0 when NONE.
- Read data is therefore valid the cycle after the request. This holds even if the grant switches at that edge, so back-to-back reads from different masters are pipelined.

dec_err:
- dec_err<=1 for one cycle after any cycle with owner_req=1 and idx>=NUM_SLAVES, read or write. Otherwise 0.

Reset mid-operation:
- Outputs return immediately to reset values.
- An in-flight read returns 0.

Test Plan:
- Reset check: reset_n=0, no requests -> m0_grant=1, m1_grant=0, m_din=0, dec_err=0, s_sel=0.
- Write/read slave 2: m0 writes 0xDEAD_BEEF_0123_4567 to 0x0205 (s_sel=4'b0100, s_wr=1 that cycle), then reads 0x0205 -> m_din=0xDEAD_BEEF_0123_4567 one cycle after the read request.
- Handover: m0_req=0, m1_req=1 at cycle n -> m1_grant=1 from n+1. Drop m1_req at cycle k -> m0_grant=1 at k+1.
- Preemption: MAX_HOLD=4, m0_req held, m1_req=1 -> m0 owns exactly 4 cycles, then m1_grant=1. With MAX_HOLD=0, m0 keeps the grant indefinitely.
- Unmapped access: owner reads 0x0400 (NUM_SLAVES=4) -> s_sel=0, dec_err=1 next cycle, m_din=0. Write to 0x0400 leaves all slaves unchanged.
- Asynchronous reset during GNT1 with a read in flight -> immediately m0_grant=1, m_din=0, hold_cnt=0.
